wb_write_arbiter: RTL and testbench

Writer side of the 32x32 integer register file. It merges single-cycle ALU results and multi-cycle results (loads, divider) onto the file's single write port (RegWrite / write_register / write_data). ALU results have priority. Multi-cycle results are buffered in a small FIFO. A starvation guard stalls the ALU path so the FIFO is guaranteed to drain.

---
 rtl/wb_write_arbiter_pkg.sv | 10 +
 rtl/wb_write_arbiter_if.sv | 24 ++
 rtl/wb_write_arbiter_fifo.sv | 38 +++
 rtl/wb_write_arbiter.sv | 56 +++++
 tb/tb_wb_write_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// wb_pkg: shared widths, write-back request record and source selector.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYP} wb_src_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: ALU/multi-cycle result inputs and register file write port.
interface wb_write_arbiter_if #(parameter int DEPTH = 4);
  import wb_pkg::*;
  logic                    alu_valid;
  logic [REG_AW-1:0]       alu_rd;
  logic [XLEN-1:0]         alu_data;
  logic                    alu_stall;
  logic                    mc_valid;
  logic                    mc_ready;
  logic [REG_AW-1:0]       mc_rd;
  logic [XLEN-1:0]         mc_data;
  logic                    RegWrite;
  logic [REG_AW-1:0]       write_register;
  logic [XLEN-1:0]         write_data;
  logic [$clog2(DEPTH):0]  fifo_count;
  modport master (
    output alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
    input  alu_stall, mc_ready, RegWrite, write_register, write_data, fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
    output alu_stall, mc_ready, RegWrite, write_register, write_data, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// wb_fifo: buffer of pending multi-cycle results; pointers wrap by natural overflow.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  wb_req_t                din_i,
  output wb_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_req_t mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= push_i ? wp_q + PW'(1) : wp_q;
      rp_q    <= pop_i ? rp_q + PW'(1) : rp_q;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  assign head_o  = mem_q[rp_q];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU and buffered multi-cycle results onto the single
// register file write port, with a head-age guard that forces the FIFO to drain.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               reset,
  wb_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(STARVE_MAX + 1);
  logic [AW-1:0] age_q, age_d;
  logic we_q;
  logic [REG_AW-1:0] wr_q;
  logic [XLEN-1:0] wd_q;
  logic full, empty, push, pop, mc_ok;
  logic [$clog2(DEPTH):0] count;
  wb_req_t head, sel;
  wb_src_t src;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop),
    .din_i({bus.mc_rd, bus.mc_data}), .head_o(head),
    .full_o(full), .empty_o(empty), .count_o(count)
  );
  assign bus.alu_stall = age_q == AW'(STARVE_MAX);
  // ready looks only at registered occupancy, so a same-cycle pop never frees a slot
  assign bus.mc_ready  = !full;
  assign mc_ok = bus.mc_valid && !full && bus.mc_rd != '0;
  always_comb begin
    src = (bus.alu_valid && bus.alu_rd != '0 && !bus.alu_stall) ? SRC_ALU
        : !empty ? SRC_FIFO
        : mc_ok ? SRC_BYP : SRC_NONE;
    sel = src == SRC_FIFO ? head
        : src == SRC_ALU ? {bus.alu_rd, bus.alu_data} : {bus.mc_rd, bus.mc_data};
    pop = src == SRC_FIFO;
    push = mc_ok && src != SRC_BYP;
    age_d = (empty || pop) ? '0 : bus.alu_stall ? age_q : age_q + AW'(1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      age_q <= '0;
      we_q  <= 1'b0;
      wr_q  <= '0;
      wd_q  <= '0;
    end else begin
      age_q <= age_d;
      we_q  <= src != SRC_NONE;
      if (src != SRC_NONE) {wr_q, wd_q} <= sel;
    end
  assign bus.RegWrite       = we_q;
  assign bus.write_register = wr_q;
  assign bus.write_data     = wd_q;
  assign bus.fifo_count     = count;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the write-back arbitration rules.
module tb_wb_write_arbiter;
  import wb_pkg::*;
  localparam int DEPTH = 4;
  localparam int SM = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  wb_write_arbiter_if #(.DEPTH(DEPTH)) bus();
  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int passed = 0;
  logic [36:0] q[$];
  int age = 0;
  logic e_we = 1'b0;
  logic [4:0] e_wr = '0;
  logic [31:0] e_wd = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic compare_all();
    chk("RegWrite", 32'(bus.RegWrite), 32'(e_we));
    chk("write_register", 32'(bus.write_register), 32'(e_wr));
    chk("write_data", bus.write_data, e_wd);
    chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    chk("alu_stall", 32'(bus.alu_stall), 32'(age == SM));
    chk("mc_ready", 32'(bus.mc_ready), 32'(q.size() < DEPTH));
  endtask
  task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                            input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bit was_empty, popped, byp, acc;
    was_empty = q.size() == 0;
    acc = mv && q.size() < DEPTH && mr != 0;
    popped = 0;
    byp = 0;
    e_we = 1'b1;
    if (av && ar != 0 && age != SM) begin e_wr = ar; e_wd = ad; end
    else if (!was_empty) begin {e_wr, e_wd} = q.pop_front(); popped = 1; end
    else if (acc) begin e_wr = mr; e_wd = md; byp = 1; end
    else e_we = 1'b0;
    if (acc && !byp) q.push_back({mr, md});
    age = (was_empty || popped) ? 0 : (age < SM ? age + 1 : SM);
  endtask
  task automatic cyc(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md);
    reset = rn;
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.mc_valid = mv; bus.mc_rd = mr; bus.mc_data = md;
    if (!rn) begin q.delete(); age = 0; e_we = 1'b0; e_wr = '0; e_wd = '0; end
    else model_step(av, ar, ad, mv, mr, md);
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, wcnt;
    logic av, mv;
    logic [4:0] ar, mr;
    logic [31:0] ad, md;
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ready", 32'(bus.mc_ready), 32'd1);
    chk("rst_we", 32'(bus.RegWrite), 32'd0);
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("alu_we", 32'(bus.RegWrite), 32'd1);
    chk("alu_wr", 32'(bus.write_register), 32'd5);
    chk("alu_wd", bus.write_data, 32'hDEADBEEF);
    cyc(1'b1, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
    chk("x0_we", 32'(bus.RegWrite), 32'd0);
    chk("x0_hold", bus.write_data, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    chk("byp_wr", 32'(bus.write_register), 32'd7);
    chk("byp_wd", bus.write_data, 32'h1234);
    chk("byp_count", 32'(bus.fifo_count), 32'd0);
    cyc(1'b1, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h11);
    cyc(1'b1, 1'b1, 5'd11, 32'hA1, 1'b1, 5'd2, 32'h22);
    cyc(1'b1, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd3, 32'h33);
    chk("cont_count", 32'(bus.fifo_count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("order_we", 32'(bus.RegWrite), 32'd1);
      chk("order_wr", 32'(bus.write_register), 32'(i));
      chk("order_wd", bus.write_data, 32'(i * 'h11));
    end
    idle();
    chk("drained_we", 32'(bus.RegWrite), 32'd0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(16 + i), 32'('h100 + i));
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_ready", 32'(bus.mc_ready), 32'd0);
    n = 0;
    while (!bus.mc_ready && n < 20) begin
      cyc(1'b1, 1'b1, 5'd24, 32'hBB, 1'b1, 5'd20, 32'h104);
      n++;
    end
    chk("full_wait", 32'(n), 32'd6);
    cyc(1'b1, 1'b1, 5'd24, 32'hBB, 1'b1, 5'd20, 32'h104);
    chk("fifth_accept", 32'(bus.fifo_count), 32'd4);
    n = 0;
    while (bus.fifo_count != 0 && n < 20) begin idle(); n++; end
    idle();
    cyc(1'b1, 1'b1, 5'd25, 32'hC0, 1'b1, 5'd9, 32'h999);
    n = 0;
    while (!bus.alu_stall && n < 20) begin
      cyc(1'b1, 1'b1, 5'd26, 32'(n), 1'b0, 5'd0, 32'd0);
      n++;
    end
    chk("starve_cycles", 32'(n), 32'd8);
    cyc(1'b1, 1'b1, 5'd27, 32'hCC, 1'b0, 5'd0, 32'd0);
    chk("starve_head_wr", 32'(bus.write_register), 32'd9);
    chk("starve_head_wd", bus.write_data, 32'h999);
    chk("starve_drop", 32'(bus.alu_stall), 32'd0);
    cyc(1'b1, 1'b1, 5'd27, 32'hCC, 1'b0, 5'd0, 32'd0);
    chk("held_alu_wr", 32'(bus.write_register), 32'd27);
    chk("held_alu_wd", bus.write_data, 32'hCC);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 5'(28 + i), 32'(i), 1'b1, 5'(13 + i), 32'('h500 + i));
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_rst_we", 32'(bus.RegWrite), 32'd0);
    chk("mid_rst_wr", 32'(bus.write_register), 32'd0);
    chk("mid_rst_wd", bus.write_data, 32'd0);
    wcnt = 0;
    for (int i = 0; i < 5; i++) begin idle(); wcnt += int'(bus.RegWrite); end
    chk("post_rst_writes", 32'(wcnt), 32'd0);
    av = 1'b0; ar = '0; ad = '0; mv = 1'b0; mr = '0; md = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!(av && bus.alu_stall)) begin
        av = $urandom_range(0, 3) != 0;
        ar = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (!mv || bus.mc_ready) begin
        mv = $urandom_range(0, 1) == 1;
        mr = 5'($urandom_range(0, 31));
        md = $urandom;
      end
      cyc(!($urandom_range(0, 149) == 0), av, ar, ad, mv, mr, md);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
